// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
// State encoding and counter-width helper used by seq_shift_add_mult.
package seq_mult_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Accumulator and shift registers for the shift-and-add multiplier.
// Optional SEQ_MULT_SIGNED_EN adds magnitude capture and sign correction.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   a_ld;
    logic [WIDTH-1:0]   b_ld;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign;
    logic sign_ld;

    // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    always_comb begin
        a_ld    = a;
        b_ld    = b;
        sign_ld = 1'b0;
        if (signed_op) begin
            if (a[WIDTH-1]) a_ld = -a;
            if (b[WIDTH-1]) b_ld = -b;
            sign_ld = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       sign <= 1'b0;
        else if (load) sign <= sign_ld;
    end

    assign result = sign ? -acc_nxt : acc_nxt;
`else
    logic unused_signed_op;

    assign a_ld             = a;
    assign b_ld             = b;
    assign unused_signed_op = signed_op;
    assign result           = acc_nxt;
`endif

    assign acc_nxt = b_sh[0] ? acc + a_sh : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
        end else if (load) begin
            acc  <= '0;
            a_sh <= {{WIDTH{1'b0}}, a_ld};
            b_sh <= b_ld;
        end else if (step) begin
            acc  <= acc_nxt;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to honour signed_op (two's-complement operands).
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_w(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               step;
    logic [2*WIDTH-1:0] result;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign step   = busy;
    assign accept = start && (state == IDLE || state == DONE);

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (step),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .result    (result)
    );

    // Latency is fixed at WIDTH steps; no early exit when b runs out of ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= CW'(WIDTH);
                    end
                end
                (state == RUN): begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state   <= DONE;
                        product <= result;
                    end
                end
                (state == DONE): begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= CW'(WIDTH);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed scoreboard bench for seq_shift_add_mult at WIDTH=8.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        signed_op = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int seen = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                          input logic sop, input logic [15:0] expv, input bit push);
        @(negedge clk);
        a = av;
        b = bv;
        signed_op = sop;
        start = 1'b1;
        if (push) exp_q.push_back(expv);
        n = 0;
        tick();
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        while (!done && n < 20) tick();
        check({tag, "_latency"}, 32'(n), 32'd9);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_product"}, 32'(product), 32'(exp_v));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        launch(8'd13, 8'd11, 1'b0, 16'd143, 1);
        finish_op("mul_13x11");
        repeat (10) tick();
        check("hold_product", 32'(product), 32'd143);
        check("done_single_pulse", 32'(done), 32'd0);

        launch(8'd255, 8'd255, 1'b0, 16'd65025, 1);
        finish_op("mul_255x255");
        launch(8'd0, 8'd200, 1'b0, 16'd0, 1);
        check("product_kept_on_start", 32'(product), 32'd65025);
        finish_op("mul_0x200");

        // Back-to-back: start stays high, new operands offered in the DONE cycle.
        @(negedge clk);
        a = 8'd5;
        b = 8'd9;
        start = 1'b1;
        exp_q.push_back(16'd45);
        n = 0;
        tick();
        finish_op("b2b_first");
        a = 8'd7;
        b = 8'd6;
        exp_q.push_back(16'd42);
        n = 0;
        tick();
        finish_op("b2b_second");
        @(negedge clk);
        start = 1'b0;
        repeat (2) tick();

        // Start during RUN is ignored.
        launch(8'd13, 8'd11, 1'b0, 16'd143, 1);
        while (n < 3) tick();
        @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        tick();
        @(negedge clk);
        start = 1'b0;
        finish_op("ignore_start");

        // Reset aborts a running operation.
        launch(8'd2, 8'd3, 1'b0, 16'd6, 0);
        while (n < 3) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        launch(8'hFD, 8'd5, 1'b0, 16'd1265, 1);
        finish_op("unsigned_fd_x5");
`ifdef SEQ_MULT_SIGNED_EN
        launch(8'hFD, 8'd5, 1'b1, 16'hFFF1, 1);
        finish_op("signed_m3_x5");
        launch(8'h80, 8'h80, 1'b1, 16'd16384, 1);
        finish_op("signed_m128_m128");
        launch(8'h80, 8'h7F, 1'b1, 16'hC080, 1);
        finish_op("signed_m128_127");
`else
        launch(8'hFD, 8'd5, 1'b1, 16'd1265, 1);
        finish_op("signed_op_ignored");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised sequential shift-and-add multiplier with a start/busy/done handshake and a deterministic latency of WIDTH+1 cycles.
- Computes a WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock, and holds the result until the next operation.
- Used by datapath/ALU blocks that trade area for latency. Replaces free-running load/shift multipliers that had no completion indication.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. Product width is 2*WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand, captured on an accepted start.
- b  in  WIDTH  multiplier, captured on an accepted start.
- signed_op  in  1  two's-complement request; used only when SIGNED_EN is defined, ignored otherwise.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result, held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE. Internal acc, a_sh, b_sh and cnt are all 0.
- rst has priority over every other input, including during RUN. It aborts the operation, and no done is produced.
- Datapath registers:
  - acc: 2*WIDTH bits.
  - a_sh: 2*WIDTH bits, zero-extended multiplicand.
  - b_sh: WIDTH bits.
  - cnt: $clog2(WIDTH+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN, with acc<=0, a_sh<={0,a}, b_sh<=b, cnt<=WIDTH.
  - start=0 -> remain in IDLE.
- RUN (busy=1), on each edge:
  - If b_sh[0], then acc<=acc+a_sh. Addition is modulo 2^(2*WIDTH); no overflow is possible.
  - a_sh<=a_sh<<1; b_sh<=b_sh>>1; cnt<=cnt-1.
  - When cnt==1 on that edge: product<=final acc value including this cycle's add, and go to DONE.
- DONE (done=1, for one cycle):
  - start=1 -> capture new operands and go to RUN (back-to-back, no idle bubble).
  - Otherwise -> IDLE.
- Latency: start accepted at edge k; done is high in the cycle following edge k+WIDTH; the next start can be accepted at edge k+WIDTH+1.
- Throughput: one product per WIDTH+1 cycles.
- start during RUN is ignored. It is not queued, and operand inputs are don't-care.
- product changes only on RUN->DONE and on rst. In particular, it does not change on an accepted start.
- No early termination: latency is fixed even when b=0 or b_sh empties early.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - signed_op is sampled with start.
  - If signed_op=1, a and b are replaced by their magnitudes at capture. Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH bits unsigned.
  - The sign flag (a[MSB]^b[MSB]) is registered at capture.
  - On RUN->DONE, product<=sign ? -acc_final : acc_final.
  - Latency is unchanged.
- Undefined: signed_op is ignored, and all operands are unsigned.

Decomposition:
- Package seq_mult_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a cnt-width helper function.
- One natural sub-module, seq_mult_datapath. It contains acc, a_sh and b_sh with load/step controls, plus the SEQ_MULT_SIGNED_EN sign logic.
- The FSM, cnt and handshake stay in the top level.

Test Plan:
- WIDTH=8, a=13, b=11, start pulsed at edge 0 -> busy for 8 cycles; done pulse after edge 8 with product=16'd143; product still 143 ten cycles later.
- a=255, b=255 -> product=16'd65025. Then a=0, b=200 -> product=0 with the same 9-cycle latency.
- start held high continuously with new operands 7*6 offered at the DONE cycle -> back-to-back: second done exactly 9 cycles after the first, product=42.
- Mid-RUN (cycle 4), pulse start with a=1, b=1 -> ignored; the original 13*11 completes with 143.
- Mid-RUN (cycle 4), pulse rst -> next cycle busy=0, done=0, product=0, and no done follows.
- SEQ_MULT_SIGNED_EN, signed_op=1:
  - -3*5 -> product=16'hFFF1.
  - -128*-128 -> 16'd16384.
  - -128*127 -> 16'hC080.
  - With signed_op=0, 8'hFD*5 -> 16'd1265.
